// File: rtl/limb_wb_bridge_if.sv
// LIMB byte bus plus Wishbone classic master signals for limb_wb_bridge.
// The master modport is the bridge; the slave modport is the EC/Wishbone side.
interface limb_wb_bridge_if #(
  parameter int AW = 36,
  parameter int DW = 32
) ();
  logic [7:0]      limb_d_in;
  logic [7:0]      limb_d_out;
  logic            limb_d_oe;
  logic            limb_stb;
  logic            limb_start;
  logic            limb_nrd;
  logic            limb_nwait;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_we_o;
  logic            wb_stb_o;
  logic            wb_cyc_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic            err_o;

  modport master (
    input  limb_d_in, limb_stb, limb_start, limb_nrd, wb_dat_i, wb_ack_i, wb_err_i,
    output limb_d_out, limb_d_oe, limb_nwait, wb_adr_o, wb_dat_o, wb_we_o,
           wb_stb_o, wb_cyc_o, wb_sel_o, err_o
  );

  modport slave (
    output limb_d_in, limb_stb, limb_start, limb_nrd, wb_dat_i, wb_ack_i, wb_err_i,
    input  limb_d_out, limb_d_oe, limb_nwait, wb_adr_o, wb_dat_o, wb_we_o,
           wb_stb_o, wb_cyc_o, wb_sel_o, err_o
  );
endinterface

// File: rtl/limb_wb_bridge.sv
// LIMB (EC) byte-stream to Wishbone classic single-beat master bridge.
// Assembles address/data bytes LSB first, auto-increments for bursts,
// prefetches the next read word, and flags bus errors/timeouts stickily.
//
// state  | meaning
// IDLE   | waiting for a start strobe
// ADDR   | collecting address bytes, LSB first
// DATA_W | collecting write-data bytes
// DATA_R | presenting read-data bytes to the EC
// BUS    | Wishbone cycle open, LIMB stalled
module limb_wb_bridge #(
  parameter int AW      = 36,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  limb_wb_bridge_if.master bus
);
  localparam int ADDR_BYTES = (AW + 7) / 8;
  localparam int DATA_BYTES = DW / 8;
  localparam int AB8        = ADDR_BYTES * 8;
  localparam int MAXB       = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int KW         = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int CW         = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA_W, DATA_R, BUS} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;      // 1 = write burst
  logic          err_q, err_d;
  logic          cyc_q, we_q, nwait_q, oe_q;
  logic          stb_ok, start, term;
  logic [AB8-1:0] adr_pad;
  logic [7:0]    d_out;

  // Next-state, byte assembly, Wishbone termination and timeout handling
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    dir_d   = dir_q;
    err_d   = err_q;
    cnt_d   = '0;
    term    = 1'b0;
    adr_pad = AB8'(adr_q);
    // nwait_q is low only in BUS, so every strobe there is dropped here
    stb_ok  = bus.limb_stb & nwait_q;
    start   = stb_ok & bus.limb_start;

    if (start) begin
      adr_d   = AW'(bus.limb_d_in);
      dir_d   = bus.limb_nrd;
      err_d   = 1'b0;
      k_d     = KW'(1);
      state_d = ADDR;
      if (ADDR_BYTES == 1) begin
        k_d     = '0;
        state_d = bus.limb_nrd ? DATA_W : BUS;
      end
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: if (stb_ok) begin
          for (int i = 0; i < ADDR_BYTES; i++)
            if (k_q == KW'(i)) adr_pad[i*8 +: 8] = bus.limb_d_in;
          // Bits above AW in the top byte are dropped by the truncation
          adr_d = AW'(adr_pad);
          if (k_q == KW'(ADDR_BYTES - 1)) begin
            k_d     = '0;
            state_d = dir_q ? DATA_W : BUS;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DATA_W: if (stb_ok) begin
          for (int i = 0; i < DATA_BYTES; i++)
            if (k_q == KW'(i)) wdat_d[i*8 +: 8] = bus.limb_d_in;
          if (k_q == KW'(DATA_BYTES - 1)) begin
            k_d     = '0;
            state_d = BUS;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DATA_R: if (stb_ok) begin
          if (k_q == KW'(DATA_BYTES - 1)) begin
            // Prefetch the next word as soon as the current one is consumed
            k_d     = '0;
            adr_d   = adr_q + AW'(1);
            state_d = BUS;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        BUS: begin
          cnt_d = cnt_q + CW'(1);
          // Error wins over a simultaneous ack
          if (bus.wb_err_i || cnt_q == CW'(TIMEOUT)) begin
            err_d  = 1'b1;
            rdat_d = '1;
            term   = 1'b1;
          end else if (bus.wb_ack_i) begin
            if (!dir_q) rdat_d = bus.wb_dat_i;
            term = 1'b1;
          end
          if (term) begin
            k_d   = '0;
            cnt_d = '0;
            if (dir_q) begin
              state_d = DATA_W;
              adr_d   = adr_q + AW'(1);
            end else begin
              state_d = DATA_R;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; bus/LIMB controls registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      nwait_q <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      cyc_q   <= (state_d == BUS);
      we_q    <= (state_d == BUS) & dir_d;
      nwait_q <= (state_d != BUS);
      oe_q    <= (state_d == DATA_R);
    end
  end

  // Read-data byte selected by the byte index
  always_comb begin
    d_out = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      if (k_q == KW'(i)) d_out = rdat_q[i*8 +: 8];
  end

  assign bus.limb_d_out = d_out;
  assign bus.limb_d_oe  = oe_q;
  assign bus.limb_nwait = nwait_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = wdat_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_stb_o   = cyc_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_sel_o   = '1;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_limb_wb_bridge.sv
// Bench for limb_wb_bridge: default-parameter instance plus an AW=16/DW=8/TIMEOUT=4 one.
module tb_limb_wb_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  limb_wb_bridge_if #(.AW(36), .DW(32)) ifa ();
  limb_wb_bridge_if #(.AW(16), .DW(8))  ifb ();

  limb_wb_bridge #(.AW(36), .DW(32), .TIMEOUT(255)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  limb_wb_bridge #(.AW(16), .DW(8),  .TIMEOUT(4))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct packed {
    logic        we;
    logic [35:0] adr;
    logic [31:0] dat;
  } wb_exp_t;

  wb_exp_t    exp_q[$];
  logic [7:0] byte_q[$];

  function automatic void push_exp(input logic we, input logic [35:0] adr, input logic [31:0] dat);
    wb_exp_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    exp_q.push_back(e);
  endfunction

  task automatic idle_inputs();
    ifa.limb_d_in = '0; ifa.limb_stb = 1'b0; ifa.limb_start = 1'b0; ifa.limb_nrd = 1'b0;
    ifa.wb_dat_i = '0; ifa.wb_ack_i = 1'b0; ifa.wb_err_i = 1'b0;
    ifb.limb_d_in = '0; ifb.limb_stb = 1'b0; ifb.limb_start = 1'b0; ifb.limb_nrd = 1'b0;
    ifb.wb_dat_i = '0; ifb.wb_ack_i = 1'b0; ifb.wb_err_i = 1'b0;
  endtask

  // One-cycle strobe; called and returns just after a falling edge
  task automatic send_a(input logic [7:0] d, input bit st, input bit nrd);
    ifa.limb_d_in = d; ifa.limb_start = st; ifa.limb_nrd = nrd; ifa.limb_stb = 1'b1;
    @(negedge clk);
    ifa.limb_stb = 1'b0; ifa.limb_start = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input bit st, input bit nrd);
    ifb.limb_d_in = d; ifb.limb_start = st; ifb.limb_nrd = nrd; ifb.limb_stb = 1'b1;
    @(negedge clk);
    ifb.limb_stb = 1'b0; ifb.limb_start = 1'b0;
  endtask

  task automatic send_addr_a(input logic [39:0] a, input bit nrd);
    send_a(a[7:0], 1'b1, nrd);
    for (int i = 1; i < 5; i++) send_a(a[i*8 +: 8], 1'b0, nrd);
  endtask

  task automatic send_word_a(input logic [31:0] d);
    for (int i = 0; i < 4; i++) send_a(d[i*8 +: 8], 1'b0, 1'b1);
  endtask

  // Wishbone slave for instance A: waits for a cycle, checks it against the
  // scoreboard, terminates it after `delay` cycles and queues the read bytes.
  task automatic wb_serve_a(input int delay, input bit do_err, input logic [31:0] rdata);
    int          n;
    bit          have;
    wb_exp_t     e;
    logic [31:0] rb;
    n = 0; have = 1'b0; e = '0; e.we = 1'b1;
    while (ifa.wb_cyc_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (ifa.wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL wb_cyc_start: cyc=%b after %0d cycles, required 1", ifa.wb_cyc_o, n);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL wb_unexpected_cycle: adr=%h we=%b, required no cycle", ifa.wb_adr_o, ifa.wb_we_o);
    end else begin
      e = exp_q.pop_front();
      have = 1'b1;
      if (ifa.wb_adr_o !== e.adr || ifa.wb_we_o !== e.we || ifa.wb_stb_o !== 1'b1 ||
          ifa.wb_sel_o !== 4'hF || ifa.limb_nwait !== 1'b0 || (e.we && ifa.wb_dat_o !== e.dat)) begin
        errors++;
        $display("FAIL wb_cycle: adr=%h we=%b dat=%h stb=%b sel=%h nwait=%b, required adr=%h we=%b dat=%h stb=1 sel=f nwait=0",
                 ifa.wb_adr_o, ifa.wb_we_o, ifa.wb_dat_o, ifa.wb_stb_o, ifa.wb_sel_o, ifa.limb_nwait,
                 e.adr, e.we, e.dat);
      end
    end
    repeat (delay) @(negedge clk);
    if (delay > 0 && have) begin
      checks++;
      if (ifa.wb_cyc_o !== 1'b1 || ifa.wb_adr_o !== e.adr) begin
        errors++;
        $display("FAIL wb_hold: cyc=%b adr=%h, required cyc=1 adr=%h", ifa.wb_cyc_o, ifa.wb_adr_o, e.adr);
      end
    end
    if (do_err) ifa.wb_err_i = 1'b1;
    else begin ifa.wb_ack_i = 1'b1; ifa.wb_dat_i = rdata; end
    rb = do_err ? 32'hFFFF_FFFF : rdata;
    if (!e.we) for (int i = 0; i < 4; i++) byte_q.push_back(rb[i*8 +: 8]);
    @(negedge clk);
    ifa.wb_ack_i = 1'b0; ifa.wb_err_i = 1'b0;
    checks++;
    if (ifa.wb_cyc_o !== 1'b0 || ifa.wb_stb_o !== 1'b0 || ifa.limb_nwait !== 1'b1) begin
      errors++;
      $display("FAIL wb_end: cyc=%b stb=%b nwait=%b, required 0 0 1", ifa.wb_cyc_o, ifa.wb_stb_o, ifa.limb_nwait);
    end
  endtask

  // EC side of a read: compare each presented byte with the scoreboard, then strobe
  task automatic read_bytes_a(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (byte_q.size() == 0) begin
        errors++;
        $display("FAIL rd_byte_queue: empty, required an expected byte");
        return;
      end
      e = byte_q.pop_front();
      if (ifa.limb_d_out !== e || ifa.limb_d_oe !== 1'b1) begin
        errors++;
        $display("FAIL rd_byte%0d: d_out=%h oe=%b, required %h oe=1", i, ifa.limb_d_out, ifa.limb_d_oe, e);
      end
      send_a(8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.wb_cyc_o !== 1'b0 || ifa.wb_stb_o !== 1'b0 || ifa.wb_we_o !== 1'b0 || ifa.limb_d_oe !== 1'b0 ||
        ifa.limb_nwait !== 1'b1 || ifa.limb_d_out !== 8'h00 || ifa.err_o !== 1'b0 ||
        ifa.wb_adr_o !== 36'h0 || ifa.wb_dat_o !== 32'h0 || ifa.wb_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_a: cyc=%b stb=%b we=%b oe=%b nwait=%b dout=%h err=%b adr=%h dat=%h sel=%h, required 0 0 0 0 1 00 0 0 0 f",
               ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o, ifa.limb_d_oe, ifa.limb_nwait, ifa.limb_d_out,
               ifa.err_o, ifa.wb_adr_o, ifa.wb_dat_o, ifa.wb_sel_o);
    end
    checks++;
    if (ifb.wb_cyc_o !== 1'b0 || ifb.limb_nwait !== 1'b1 || ifb.wb_adr_o !== 16'h0 || ifb.wb_sel_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: cyc=%b nwait=%b adr=%h sel=%b, required 0 1 0000 1",
               ifb.wb_cyc_o, ifb.limb_nwait, ifb.wb_adr_o, ifb.wb_sel_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_a(8'h55, 1'b0, 1'b1);
    send_a(8'h66, 1'b0, 1'b1);
    checks++;
    if (ifa.wb_cyc_o !== 1'b0 || ifa.limb_nwait !== 1'b1 || ifa.wb_adr_o !== 36'h0) begin
      errors++;
      $display("FAIL idle_ignore: cyc=%b nwait=%b adr=%h, required 0 1 0", ifa.wb_cyc_o, ifa.limb_nwait, ifa.wb_adr_o);
    end
  endtask

  task automatic test_write();
    push_exp(1'b1, 36'h912345678, 32'h11223344);
    send_addr_a(40'h0912345678, 1'b1);
    send_word_a(32'h11223344);
    wb_serve_a(2, 1'b0, 32'h0);
    checks++;
    if (ifa.err_o !== 1'b0 || ifa.wb_adr_o !== 36'h912345679) begin
      errors++;
      $display("FAIL write_after: err=%b adr=%h, required 0 912345679", ifa.err_o, ifa.wb_adr_o);
    end
  endtask

  task automatic test_read_burst();
    push_exp(1'b0, 36'h010, 32'h0);
    send_addr_a(40'h10, 1'b0);
    wb_serve_a(0, 1'b0, 32'hCAFEBABE);
    push_exp(1'b0, 36'h011, 32'h0);
    read_bytes_a(4);
    wb_serve_a(1, 1'b0, 32'h01020304);
    push_exp(1'b0, 36'h012, 32'h0);
    read_bytes_a(4);
    wb_serve_a(0, 1'b0, 32'h0);
    byte_q.delete();
  endtask

  task automatic test_wrap();
    push_exp(1'b1, 36'hFFFFFFFFF, 32'hA1A2A3A4);
    push_exp(1'b1, 36'h000000000, 32'hB1B2B3B4);
    send_addr_a(40'hFFFFFFFFFF, 1'b1);
    send_word_a(32'hA1A2A3A4);
    wb_serve_a(0, 1'b0, 32'h0);
    send_word_a(32'hB1B2B3B4);
    wb_serve_a(1, 1'b0, 32'h0);
  endtask

  task automatic test_error();
    push_exp(1'b0, 36'h040, 32'h0);
    send_addr_a(40'h40, 1'b0);
    wb_serve_a(0, 1'b1, 32'h0);
    checks++;
    if (ifa.err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b, required 1", ifa.err_o);
    end
    push_exp(1'b0, 36'h041, 32'h0);
    read_bytes_a(4);
    wb_serve_a(0, 1'b0, 32'h12345678);
    checks++;
    if (ifa.err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, required 1", ifa.err_o);
    end
    byte_q.delete();
    send_a(8'h00, 1'b1, 1'b1);
    checks++;
    if (ifa.err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, required 0", ifa.err_o);
    end
  endtask

  task automatic test_protocol_edges();
    push_exp(1'b1, 36'h100, 32'hDEADBEEF);
    send_addr_a(40'h100, 1'b1);
    send_word_a(32'hDEADBEEF);
    send_a(8'hAA, 1'b1, 1'b0);
    send_a(8'h55, 1'b0, 1'b0);
    checks++;
    if (ifa.wb_cyc_o !== 1'b1 || ifa.wb_adr_o !== 36'h100 || ifa.wb_dat_o !== 32'hDEADBEEF || ifa.wb_we_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore: cyc=%b adr=%h dat=%h we=%b, required 1 100 deadbeef 1",
               ifa.wb_cyc_o, ifa.wb_adr_o, ifa.wb_dat_o, ifa.wb_we_o);
    end
    wb_serve_a(0, 1'b0, 32'h0);
    push_exp(1'b1, 36'h101, 32'h0BADF00D);
    send_word_a(32'h0BADF00D);
    wb_serve_a(0, 1'b0, 32'h0);
    send_a(8'h11, 1'b0, 1'b1);
    send_a(8'h22, 1'b0, 1'b1);
    send_a(8'h20, 1'b1, 1'b0);
    checks++;
    if (ifa.wb_cyc_o !== 1'b0 || ifa.limb_nwait !== 1'b1) begin
      errors++;
      $display("FAIL abort_partial: cyc=%b nwait=%b, required 0 1", ifa.wb_cyc_o, ifa.limb_nwait);
    end
    push_exp(1'b0, 36'h020, 32'h0);
    for (int i = 0; i < 4; i++) send_a(8'h00, 1'b0, 1'b0);
    wb_serve_a(0, 1'b0, 32'h55667788);
    read_bytes_a(1);
    byte_q.delete();
  endtask

  task automatic test_small_params();
    send_b(8'h34, 1'b1, 1'b0);
    checks++;
    if (ifb.wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL b_addr_one_byte: cyc=%b, required 0", ifb.wb_cyc_o);
    end
    send_b(8'h12, 1'b0, 1'b0);
    checks++;
    if (ifb.wb_cyc_o !== 1'b1 || ifb.wb_we_o !== 1'b0 || ifb.wb_adr_o !== 16'h1234 || ifb.wb_sel_o !== 1'b1) begin
      errors++;
      $display("FAIL b_read_cycle: cyc=%b we=%b adr=%h sel=%b, required 1 0 1234 1",
               ifb.wb_cyc_o, ifb.wb_we_o, ifb.wb_adr_o, ifb.wb_sel_o);
    end
    ifb.wb_dat_i = 8'hA5; ifb.wb_ack_i = 1'b1;
    @(negedge clk);
    ifb.wb_ack_i = 1'b0;
    checks++;
    if (ifb.wb_cyc_o !== 1'b0 || ifb.limb_d_out !== 8'hA5 || ifb.limb_d_oe !== 1'b1) begin
      errors++;
      $display("FAIL b_read_data: cyc=%b dout=%h oe=%b, required 0 a5 1", ifb.wb_cyc_o, ifb.limb_d_out, ifb.limb_d_oe);
    end
    send_b(8'hEF, 1'b1, 1'b1);
    send_b(8'hBE, 1'b0, 1'b1);
    checks++;
    if (ifb.wb_cyc_o !== 1'b0 || ifb.limb_d_oe !== 1'b0) begin
      errors++;
      $display("FAIL b_wait_data: cyc=%b oe=%b, required 0 0", ifb.wb_cyc_o, ifb.limb_d_oe);
    end
    send_b(8'h5A, 1'b0, 1'b1);
    checks++;
    if (ifb.wb_cyc_o !== 1'b1 || ifb.wb_we_o !== 1'b1 || ifb.wb_adr_o !== 16'hBEEF || ifb.wb_dat_o !== 8'h5A) begin
      errors++;
      $display("FAIL b_write_cycle: cyc=%b we=%b adr=%h dat=%h, required 1 1 beef 5a",
               ifb.wb_cyc_o, ifb.wb_we_o, ifb.wb_adr_o, ifb.wb_dat_o);
    end
    ifb.wb_ack_i = 1'b1;
    @(negedge clk);
    ifb.wb_ack_i = 1'b0;
    checks++;
    if (ifb.wb_cyc_o !== 1'b0 || ifb.wb_adr_o !== 16'hBEF0 || ifb.err_o !== 1'b0) begin
      errors++;
      $display("FAIL b_write_end: cyc=%b adr=%h err=%b, required 0 bef0 0", ifb.wb_cyc_o, ifb.wb_adr_o, ifb.err_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    send_b(8'h77, 1'b0, 1'b1);
    checks++;
    if (ifb.wb_adr_o !== 16'hBEF0 || ifb.wb_dat_o !== 8'h77 || ifb.limb_nwait !== 1'b0) begin
      errors++;
      $display("FAIL to_start: adr=%h dat=%h nwait=%b, required bef0 77 0", ifb.wb_adr_o, ifb.wb_dat_o, ifb.limb_nwait);
    end
    n = 0;
    while (ifb.wb_cyc_o === 1'b1 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL to_length: bus cycles=%0d, required 5", n);
    end
    checks++;
    if (ifb.limb_nwait !== 1'b1 || ifb.err_o !== 1'b1 || ifb.limb_d_out !== 8'hFF || ifb.wb_adr_o !== 16'hBEF1) begin
      errors++;
      $display("FAIL to_end: nwait=%b err=%b dout=%h adr=%h, required 1 1 ff bef1",
               ifb.limb_nwait, ifb.err_o, ifb.limb_d_out, ifb.wb_adr_o);
    end
  endtask

  task automatic test_reset_in_bus();
    send_addr_a(40'h300, 1'b1);
    send_word_a(32'h00000001);
    checks++;
    if (ifa.wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_entry: cyc=%b, required 1", ifa.wb_cyc_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.wb_cyc_o !== 1'b0 || ifa.wb_stb_o !== 1'b0 || ifa.wb_we_o !== 1'b0 || ifa.limb_nwait !== 1'b1 ||
        ifa.limb_d_oe !== 1'b0 || ifa.limb_d_out !== 8'h00 || ifa.err_o !== 1'b0 ||
        ifa.wb_adr_o !== 36'h0 || ifa.wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: cyc=%b stb=%b we=%b nwait=%b oe=%b dout=%h err=%b adr=%h dat=%h, required 0 0 0 1 0 00 0 0 0",
               ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o, ifa.limb_nwait, ifa.limb_d_oe, ifa.limb_d_out,
               ifa.err_o, ifa.wb_adr_o, ifa.wb_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_burst();
    test_wrap();
    test_error();
    test_protocol_edges();
    test_small_params();
    test_timeout();
    test_reset_in_bus();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d cycles still expected, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
